// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared constants, bar descriptor layout and FSM states for the ball renderer (TARGET_DRAW_EN adds the target state)
package ball_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int BAR_LEN = 3;
    localparam int BAR_W   = 16;

    // Bar descriptor layout
    localparam int BAR_VERT_BIT = 0;
    localparam int BAR_X_LSB    = 1;
    localparam int BAR_X_MSB    = 8;
    localparam int BAR_Y_LSB    = 9;
    localparam int BAR_Y_MSB    = 15;

    localparam logic [7:0] TARGET_X  = 8'd60;
    localparam logic [6:0] TARGET_Y0 = 7'd58;
    localparam logic [6:0] TARGET_Y1 = 7'd62;

    localparam logic [2:0] COLOUR_BG     = 3'b000;
    localparam logic [2:0] COLOUR_BAR    = 3'b111;
    localparam logic [2:0] COLOUR_BALL   = 3'b100;
    localparam logic [2:0] COLOUR_TARGET = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_BARS,
        ST_BALL,
`ifdef TARGET_DRAW_EN
        ST_TARGET,
`endif
        ST_DONE
    } state_t;

    // Coordinates carry one extra bit so +seg overflow is seen, not wrapped
    function automatic logic on_screen(input logic [8:0] x, input logic [7:0] y);
        return (x < 9'(SCREEN_W)) && (y < 8'(SCREEN_H));
    endfunction

endpackage

// File: rtl/ball_renderer_if.sv
// rtl/ball_renderer_if.sv - engine-side inputs and VGA plot-port outputs of the ball renderer
interface ball_renderer_if #(
    parameter int BAR_COUNT = 5
);
    logic                    frame_tick;
    logic                    draw;
    logic [7:0]              xpos;
    logic [7:0]              ypos;
    logic [16*BAR_COUNT-1:0] bars;
    logic [7:0]              vga_x;
    logic [6:0]              vga_y;
    logic [2:0]              vga_colour;
    logic                    vga_plot;
    logic                    busy;
    logic                    done;

    // Engine / frame source side
    modport master (
        output frame_tick, draw, xpos, ypos, bars,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    // Renderer side
    modport slave (
        input  frame_tick, draw, xpos, ypos, bars,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done
    );
endinterface

// File: rtl/bar_pixel_addr.sv
// rtl/bar_pixel_addr.sv - pixel address of one segment of a bar descriptor, with on-screen flag
module bar_pixel_addr
    import ball_pkg::*;
(
    input  logic [BAR_W-1:0] desc_i,
    input  logic [1:0]       seg_i,
    output logic [7:0]       x_o,
    output logic [6:0]       y_o,
    output logic             on_screen_o
);
    logic [8:0] x_full;
    logic [7:0] y_full;

    // Step along the bar's axis; the other axis stays at the origin
    always_comb begin
        x_full = {1'b0, desc_i[BAR_X_MSB:BAR_X_LSB]};
        y_full = {1'b0, desc_i[BAR_Y_MSB:BAR_Y_LSB]};
        if (desc_i[BAR_VERT_BIT]) begin
            y_full = y_full + {6'd0, seg_i};
        end else begin
            x_full = x_full + {7'd0, seg_i};
        end
        on_screen_o = on_screen(x_full, y_full);
        x_o         = x_full[7:0];
        y_o         = y_full[6:0];
    end
endmodule

// File: rtl/ball_renderer.sv
// rtl/ball_renderer.sv - per-frame erase/bars/ball pixel serialiser for the VGA plot port (TARGET_DRAW_EN adds target drawing)
module ball_renderer
    import ball_pkg::*;
#(
    parameter int         BAR_COUNT     = 5,
    parameter logic [2:0] BG_COLOUR     = COLOUR_BG,
    parameter logic [2:0] BAR_COLOUR    = COLOUR_BAR,
    parameter logic [2:0] BALL_COLOUR   = COLOUR_BALL,
    parameter logic [2:0] TARGET_COLOUR = COLOUR_TARGET
) (
    input  logic            clock,
    input  logic            reset,
    ball_renderer_if.slave  bus
);
    localparam int IDX_W = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1;
    localparam logic [1:0] SEG_LAST = 2'(BAR_LEN - 1);

    state_t state_q, state_d;

    logic [IDX_W-1:0] bar_idx_q, bar_idx_d;
    logic [1:0]       seg_q, seg_d;
`ifdef TARGET_DRAW_EN
    logic [2:0]       tgt_q, tgt_d;
`endif

    // Frame snapshot and last drawn ball position
    logic                     sh_draw_q;
    logic [7:0]               sh_x_q;
    logic [6:0]               sh_y_q;
    logic [BAR_W*BAR_COUNT-1:0] sh_bars_q;
    logic                     old_valid_q;
    logic [7:0]               old_x_q;
    logic [6:0]               old_y_q;

    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [BAR_W-1:0] bar_arr [BAR_COUNT];
    logic [7:0]       bar_x;
    logic [6:0]       bar_y;
    logic             bar_on;
    logic             last_bar_pix;

    // Split the shadow bar bus into descriptors for indexing by bar_idx
    always_comb begin
        for (int i = 0; i < BAR_COUNT; i++) begin
            bar_arr[i] = sh_bars_q[i*BAR_W +: BAR_W];
        end
    end

    bar_pixel_addr u_bar_pixel_addr (
        .desc_i      (bar_arr[bar_idx_q]),
        .seg_i       (seg_q),
        .x_o         (bar_x),
        .y_o         (bar_y),
        .on_screen_o (bar_on)
    );

    assign last_bar_pix = (bar_idx_q == IDX_W'(BAR_COUNT - 1)) && (seg_q == SEG_LAST);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ticks outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.frame_tick) state_d = ST_ERASE;
            ST_ERASE: state_d = ST_BARS;
            ST_BARS:  if (last_bar_pix) state_d = ST_BALL;
`ifdef TARGET_DRAW_EN
            ST_BALL:   state_d = ST_TARGET;
            ST_TARGET: if (tgt_q == 3'(TARGET_Y1 - TARGET_Y0)) state_d = ST_DONE;
`else
            ST_BALL:  state_d = ST_DONE;
`endif
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pixel, strobe and counter next values for the current state
    always_comb begin
        vga_plot_d   = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        busy_d       = (state_q != ST_IDLE);
        done_d       = 1'b0;
        bar_idx_d    = '0;
        seg_d        = '0;
`ifdef TARGET_DRAW_EN
        tgt_d        = '0;
`endif
        case (state_q)
            ST_ERASE: begin
                if (old_valid_q && on_screen({1'b0, old_x_q}, {1'b0, old_y_q})) begin
                    vga_plot_d   = 1'b1;
                    vga_x_d      = old_x_q;
                    vga_y_d      = old_y_q;
                    vga_colour_d = BG_COLOUR;
                end
            end
            ST_BARS: begin
                if (seg_q == SEG_LAST) begin
                    seg_d     = '0;
                    bar_idx_d = bar_idx_q + 1'b1;
                end else begin
                    seg_d     = seg_q + 1'b1;
                    bar_idx_d = bar_idx_q;
                end
                if (bar_on) begin
                    vga_plot_d   = 1'b1;
                    vga_x_d      = bar_x;
                    vga_y_d      = bar_y;
                    vga_colour_d = BAR_COLOUR;
                end
            end
            ST_BALL: begin
                if (sh_draw_q && on_screen({1'b0, sh_x_q}, {1'b0, sh_y_q})) begin
                    vga_plot_d   = 1'b1;
                    vga_x_d      = sh_x_q;
                    vga_y_d      = sh_y_q;
                    vga_colour_d = BALL_COLOUR;
                end
            end
`ifdef TARGET_DRAW_EN
            ST_TARGET: begin
                tgt_d        = tgt_q + 1'b1;
                vga_plot_d   = 1'b1;
                vga_x_d      = TARGET_X;
                vga_y_d      = TARGET_Y0 + {4'd0, tgt_q};
                vga_colour_d = TARGET_COLOUR;
            end
`endif
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

`ifndef TARGET_DRAW_EN
    logic unused_bits;
    assign unused_bits = ^{bus.ypos[7], TARGET_COLOUR};
`else
    logic unused_bits;
    assign unused_bits = bus.ypos[7];
`endif

    // Pass counters
    always_ff @(posedge clock) begin
        if (reset) begin
            bar_idx_q <= '0;
            seg_q     <= '0;
`ifdef TARGET_DRAW_EN
            tgt_q     <= '0;
`endif
        end else begin
            bar_idx_q <= bar_idx_d;
            seg_q     <= seg_d;
`ifdef TARGET_DRAW_EN
            tgt_q     <= tgt_d;
`endif
        end
    end

    // Snapshot inputs on an accepted tick; remember where the ball was drawn
    always_ff @(posedge clock) begin
        if (reset) begin
            sh_draw_q   <= 1'b0;
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            sh_bars_q   <= '0;
            old_valid_q <= 1'b0;
            old_x_q     <= '0;
            old_y_q     <= '0;
        end else begin
            if (state_q == ST_IDLE && bus.frame_tick) begin
                sh_draw_q <= bus.draw;
                sh_x_q    <= bus.xpos;
                sh_y_q    <= bus.ypos[6:0];
                sh_bars_q <= bus.bars;
            end
            if (state_q == ST_BALL) begin
                old_valid_q <= sh_draw_q;
                if (sh_draw_q) begin
                    old_x_q <= sh_x_q;
                    old_y_q <= sh_y_q;
                end
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
